// File: rtl/shape_rasterizer_if.sv
// Handshake and pixel bus between the GPU control unit and the shape rasterizer.
// The control unit is the master: it issues shape commands and acknowledges
// pixels. The rasterizer is the slave: it presents pixels and reports completion.
interface shape_rasterizer_if #(
   parameter int COORD_W = 10,
   parameter int COLOR_W = 8
);
   logic               new_shape;
   logic [1:0]         opcode;
   logic [COORD_W-1:0] x0;
   logic [COORD_W-1:0] y0;
   logic [COORD_W-1:0] x1;
   logic [COORD_W-1:0] y1;
   logic [COLOR_W-1:0] color;
   logic               send_data;
   logic               data_ready;
   logic [COORD_W-1:0] pixel_x;
   logic [COORD_W-1:0] pixel_y;
   logic [COLOR_W-1:0] pixel_color;
   logic               shape_done;

   modport master (
      output new_shape, opcode, x0, y0, x1, y1, color, send_data,
      input  data_ready, pixel_x, pixel_y, pixel_color, shape_done
   );

   modport slave (
      input  new_shape, opcode, x0, y0, x1, y1, color, send_data,
      output data_ready, pixel_x, pixel_y, pixel_color, shape_done
   );
endinterface

// File: rtl/shape_rasterizer.sv
// Shape rasterizer: captures a point / line / filled-rectangle command and
// walks it one pixel per handshake. Lines use Bresenham; rectangles are walked
// row-major with x fastest. The pixel output registers double as the walk
// position, so they only move on the edge that enters EMIT.
module shape_rasterizer #(
   parameter int COORD_W = 10,
   parameter int COLOR_W = 8
) (
   input logic              clk,
   input logic              n_reset,
   shape_rasterizer_if.slave bus
);

   // Signed width wide enough for 2*err without overflow.
   localparam int SW = COORD_W + 2;
   localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

   localparam logic [1:0] OP_POINT = 2'b00;
   localparam logic [1:0] OP_LINE  = 2'b01;
   localparam logic [1:0] OP_RECT  = 2'b10;

   typedef enum logic [2:0] {IDLE, SETUP, EMIT, STEP, DONE} state_t;

   state_t              state;
   logic [1:0]          op_reg;
   logic [COORD_W-1:0]  x0_reg, y0_reg, x1_reg, y1_reg;
   logic [COLOR_W-1:0]  color_reg;
   logic signed [SW-1:0] dx_reg, dy_reg, err_reg;
   logic                sx_neg_reg, sy_neg_reg;
   logic [COORD_W-1:0]  x_min_reg;
   logic [COORD_W-1:0]  end_x_reg, end_y_reg;

   logic [COORD_W-1:0]  adx, ady, x_lo, x_hi, y_lo, y_hi;
   logic signed [SW-1:0] dx_init, dy_init, err_init;
   logic signed [SW-1:0] e2, err_step;
   logic                step_x, step_y;
   logic [COORD_W-1:0]  line_x_next, line_y_next;
   logic                row_end;
   logic [COORD_W-1:0]  rect_x_next, rect_y_next;
   logic                is_last;

   // Walk setup terms from the captured vertices, and the next-pixel terms
   // from the current position.
   always_comb begin
      adx  = (x1_reg >= x0_reg) ? (x1_reg - x0_reg) : (x0_reg - x1_reg);
      ady  = (y1_reg >= y0_reg) ? (y1_reg - y0_reg) : (y0_reg - y1_reg);
      x_lo = (x1_reg < x0_reg) ? x1_reg : x0_reg;
      x_hi = (x1_reg < x0_reg) ? x0_reg : x1_reg;
      y_lo = (y1_reg < y0_reg) ? y1_reg : y0_reg;
      y_hi = (y1_reg < y0_reg) ? y0_reg : y1_reg;

      dx_init  = $signed({2'b00, adx});
      dy_init  = -$signed({2'b00, ady});
      err_init = dx_init + dy_init;

      // Both Bresenham decisions use the pre-step error term.
      e2       = err_reg <<< 1;
      step_x   = (e2 >= dy_reg);
      step_y   = (e2 <= dx_reg);
      err_step = err_reg + (step_x ? dy_reg : {SW{1'b0}})
                         + (step_y ? dx_reg : {SW{1'b0}});

      line_x_next = bus.pixel_x;
      if (step_x) line_x_next = sx_neg_reg ? (bus.pixel_x - ONE) : (bus.pixel_x + ONE);
      line_y_next = bus.pixel_y;
      if (step_y) line_y_next = sy_neg_reg ? (bus.pixel_y - ONE) : (bus.pixel_y + ONE);

      row_end     = (bus.pixel_x == end_x_reg);
      rect_x_next = row_end ? x_min_reg : (bus.pixel_x + ONE);
      rect_y_next = row_end ? (bus.pixel_y + ONE) : bus.pixel_y;

      // Every shape ends on its recorded end vertex.
      is_last = (bus.pixel_x == end_x_reg) && (bus.pixel_y == end_y_reg);
   end

   // Control FSM with registered outputs; new_shape aborts from any state.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state           <= IDLE;
         op_reg          <= '0;
         x0_reg          <= '0;
         y0_reg          <= '0;
         x1_reg          <= '0;
         y1_reg          <= '0;
         color_reg       <= '0;
         dx_reg          <= '0;
         dy_reg          <= '0;
         err_reg         <= '0;
         sx_neg_reg      <= 1'b0;
         sy_neg_reg      <= 1'b0;
         x_min_reg       <= '0;
         end_x_reg       <= '0;
         end_y_reg       <= '0;
         bus.data_ready  <= 1'b0;
         bus.shape_done  <= 1'b0;
         bus.pixel_x     <= '0;
         bus.pixel_y     <= '0;
         bus.pixel_color <= '0;
      end else if (bus.new_shape) begin
         op_reg         <= bus.opcode;
         x0_reg         <= bus.x0;
         y0_reg         <= bus.y0;
         x1_reg         <= bus.x1;
         y1_reg         <= bus.y1;
         color_reg      <= bus.color;
         bus.data_ready <= 1'b0;
         bus.shape_done <= 1'b0;
         state          <= SETUP;
      end else begin
         case (state)
            IDLE: begin
            end
            SETUP: begin
               dx_reg     <= dx_init;
               dy_reg     <= dy_init;
               err_reg    <= err_init;
               sx_neg_reg <= (x1_reg < x0_reg);
               sy_neg_reg <= (y1_reg < y0_reg);
               x_min_reg  <= x_lo;
               if (op_reg == OP_POINT || op_reg == OP_LINE || op_reg == OP_RECT) begin
                  if (op_reg == OP_RECT) begin
                     bus.pixel_x <= x_lo;
                     bus.pixel_y <= y_lo;
                     end_x_reg   <= x_hi;
                     end_y_reg   <= y_hi;
                  end else begin
                     bus.pixel_x <= x0_reg;
                     bus.pixel_y <= y0_reg;
                     end_x_reg   <= (op_reg == OP_LINE) ? x1_reg : x0_reg;
                     end_y_reg   <= (op_reg == OP_LINE) ? y1_reg : y0_reg;
                  end
                  bus.pixel_color <= color_reg;
                  bus.data_ready  <= 1'b1;
                  state           <= EMIT;
               end else begin
                  // Reserved opcode: completes immediately with no pixels.
                  bus.shape_done <= 1'b1;
                  state          <= DONE;
               end
            end
            EMIT: begin
               if (bus.send_data) begin
                  bus.data_ready <= 1'b0;
                  if (is_last) begin
                     bus.shape_done <= 1'b1;
                     state          <= DONE;
                  end else begin
                     state <= STEP;
                  end
               end
            end
            STEP: begin
               if (op_reg == OP_LINE) begin
                  bus.pixel_x <= line_x_next;
                  bus.pixel_y <= line_y_next;
                  err_reg     <= err_step;
               end else begin
                  bus.pixel_x <= rect_x_next;
                  bus.pixel_y <= rect_y_next;
               end
               bus.data_ready <= 1'b1;
               state          <= EMIT;
            end
            DONE: begin
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shape_rasterizer.sv
// Directed bench for shape_rasterizer: a table of shapes with hand-derived
// pixel lists, plus hand-written reset-mid-shape and abort sequences.
module tb_shape_rasterizer;

   logic clk;
   logic n_reset;

   shape_rasterizer_if #(.COORD_W(10), .COLOR_W(8)) bus ();

   shape_rasterizer #(.COORD_W(10), .COLOR_W(8)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]       op;
      logic [9:0]       x0, y0, x1, y1;
      logic [7:0]       col;
      int               npix;
      int               delay;
      bit               spam;
      logic [3:0][9:0]  px;
      logic [3:0][9:0]  py;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t tbl [9];

   function automatic vec_t mk(input int op, input int x0, input int y0,
                               input int x1, input int y1, input int col,
                               input int n, input int dly, input bit spam,
                               input int ax0, input int ay0, input int ax1, input int ay1,
                               input int ax2, input int ay2, input int ax3, input int ay3);
      vec_t v;
      v.op    = op[1:0];
      v.x0    = x0[9:0];
      v.y0    = y0[9:0];
      v.x1    = x1[9:0];
      v.y1    = y1[9:0];
      v.col   = col[7:0];
      v.npix  = n;
      v.delay = dly;
      v.spam  = spam;
      v.px[0] = ax0[9:0]; v.py[0] = ay0[9:0];
      v.px[1] = ax1[9:0]; v.py[1] = ay1[9:0];
      v.px[2] = ax2[9:0]; v.py[2] = ay2[9:0];
      v.px[3] = ax3[9:0]; v.py[3] = ay3[9:0];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Issue one shape and walk it. If stop_after >= 0, return while pixel
   // stop_after is being presented (not yet accepted).
   task automatic run(input string tag, input vec_t v, input int stop_after);
      bus.opcode    = v.op;
      bus.x0        = v.x0;
      bus.y0        = v.y0;
      bus.x1        = v.x1;
      bus.y1        = v.y1;
      bus.color     = v.col;
      bus.new_shape = 1'b1;
      tick();
      bus.new_shape = 1'b0;
      check({tag, " setup_ready"}, int'(bus.data_ready), 0);
      check({tag, " setup_done"}, int'(bus.shape_done), 0);
      if (v.spam) bus.send_data = 1'b1;
      tick();
      bus.send_data = 1'b0;
      if (v.op == 2'b11) begin
         check({tag, " rsv_done"}, int'(bus.shape_done), 1);
         check({tag, " rsv_ready"}, int'(bus.data_ready), 0);
         tick();
         check({tag, " rsv_ready_hold"}, int'(bus.data_ready), 0);
         check({tag, " rsv_done_hold"}, int'(bus.shape_done), 1);
         $display("%s: reserved opcode, no pixels", tag);
         return;
      end
      for (int p = 0; p < v.npix; p++) begin
         check({tag, " emit_ready"}, int'(bus.data_ready), 1);
         check({tag, " emit_done"}, int'(bus.shape_done), 0);
         check({tag, " pixel_x"}, int'(bus.pixel_x), int'(v.px[p]));
         check({tag, " pixel_y"}, int'(bus.pixel_y), int'(v.py[p]));
         check({tag, " pixel_color"}, int'(bus.pixel_color), int'(v.col));
         if (p == stop_after) return;
         repeat (v.delay) tick();
         if (v.delay > 0) begin
            check({tag, " hold_ready"}, int'(bus.data_ready), 1);
            check({tag, " hold_x"}, int'(bus.pixel_x), int'(v.px[p]));
            check({tag, " hold_y"}, int'(bus.pixel_y), int'(v.py[p]));
         end
         bus.send_data = 1'b1;
         tick();
         bus.send_data = 1'b0;
         $display("%s: pixel %0d (%0d,%0d) colour 0x%0h accepted", tag, p,
                  v.px[p], v.py[p], v.col);
         check({tag, " accept_ready"}, int'(bus.data_ready), 0);
         check({tag, " accept_done"}, int'(bus.shape_done), (p == v.npix - 1) ? 1 : 0);
         if (p != v.npix - 1) begin
            if (v.spam) bus.send_data = 1'b1;
            tick();
            bus.send_data = 1'b0;
         end
      end
      tick();
      check({tag, " done_hold"}, int'(bus.shape_done), 1);
      check({tag, " done_ready"}, int'(bus.data_ready), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_reset       = 1'b0;
      bus.new_shape = 1'b0;
      bus.send_data = 1'b0;
      bus.opcode    = 2'b00;
      bus.x0        = '0;
      bus.y0        = '0;
      bus.x1        = '0;
      bus.y1        = '0;
      bus.color     = '0;

      //          op  x0 y0 x1 y1 col   n  dly spam  pixel list
      tbl[0] = mk(1,  0, 0, 3, 1, 8'h11, 4, 2, 1'b0, 0,0, 1,0, 2,1, 3,1);
      tbl[1] = mk(1,  3, 1, 0, 0, 8'h22, 4, 0, 1'b1, 3,1, 2,1, 1,0, 0,0);
      tbl[2] = mk(1,  2, 5, 2, 2, 8'h33, 4, 1, 1'b0, 2,5, 2,4, 2,3, 2,2);
      tbl[3] = mk(2,  5, 2, 4, 3, 8'h44, 4, 0, 1'b1, 4,2, 5,2, 4,3, 5,3);
      tbl[4] = mk(2,  6, 6, 6, 6, 8'h55, 1, 1, 1'b0, 6,6, 0,0, 0,0, 0,0);
      tbl[5] = mk(0,  7, 9, 1, 1, 8'h66, 1, 0, 1'b1, 7,9, 0,0, 0,0, 0,0);
      tbl[6] = mk(3,  1, 2, 3, 4, 8'h77, 0, 0, 1'b1, 0,0, 0,0, 0,0, 0,0);
      tbl[7] = mk(1,  0, 0, 2, 2, 8'h88, 3, 0, 1'b0, 0,0, 1,1, 2,2, 0,0);
      tbl[8] = mk(1,  0, 0, 1, 3, 8'h99, 4, 1, 1'b1, 0,0, 0,1, 1,2, 1,3);

      repeat (2) tick();
      check("reset data_ready", int'(bus.data_ready), 0);
      check("reset shape_done", int'(bus.shape_done), 0);
      check("reset pixel_x", int'(bus.pixel_x), 0);
      check("reset pixel_y", int'(bus.pixel_y), 0);
      check("reset pixel_color", int'(bus.pixel_color), 0);
      n_reset = 1'b1;
      tick();
      check("idle data_ready", int'(bus.data_ready), 0);

      for (int i = 0; i < 9; i++) begin
         run($sformatf("vec%0d", i), tbl[i], -1);
         tick();
      end

      // Reset while the third pixel of a line is presented.
      run("rst_line", tbl[0], 2);
      n_reset = 1'b0;
      #1;
      check("midreset data_ready", int'(bus.data_ready), 0);
      check("midreset shape_done", int'(bus.shape_done), 0);
      check("midreset pixel_x", int'(bus.pixel_x), 0);
      check("midreset pixel_y", int'(bus.pixel_y), 0);
      check("midreset pixel_color", int'(bus.pixel_color), 0);
      #2;
      n_reset = 1'b1;
      tick();
      check("postreset data_ready", int'(bus.data_ready), 0);
      check("postreset shape_done", int'(bus.shape_done), 0);
      run("post_rst_point", mk(0, 7, 9, 0, 0, 8'h3C, 1, 0, 1'b0,
                               7,9, 0,0, 0,0, 0,0), -1);

      // Abort a rectangle in EMIT with a new line command.
      tick();
      run("abort_rect", tbl[3], 1);
      run("abort_line", mk(1, 0, 0, 2, 0, 8'hA5, 3, 1, 1'b0,
                           0,0, 1,0, 2,0, 0,0), -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
